// File: rtl/memory_ctrl_cfg_arbiter.sv
// rtl/memory_ctrl_cfg_arbiter.sv - round-robin share of the memory_ctrl AXI4-Lite register slave between two requesters
module memory_ctrl_cfg_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          done,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_BWAIT,
        S_RD,
        S_RWAIT
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                cur_q;
    logic                last_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic [1:0]          done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic [1:0]          req_eff;
    logic                grant_en;
    logic                grant_port;
    logic                grant_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                aw_open;
    logic                w_open;
    logic                b_fire;
    logic                r_fire;
    logic                unused_resp_lsb;

    // The port just completed still holds req during its done cycle; masking it
    // lets the other port win immediately and stops a duplicate transaction.
    always_comb begin
        req_eff    = req & ~done_q;
        grant_port = (req_eff == 2'b11) ? ~last_q : req_eff[1];
        grant_en   = (state_q == S_IDLE) && (req_eff != 2'b00);
        grant_we   = grant_port ? we[1] : we[0];
        sel_addr   = grant_port ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
        sel_wdata  = grant_port ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        aw_open    = awvalid_q & ~m_axi_awready;
        w_open     = wvalid_q & ~m_axi_wready;
        b_fire     = (state_q == S_BWAIT) && m_axi_bvalid;
        r_fire     = (state_q == S_RWAIT) && m_axi_rvalid;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_en) begin
                    state_d = grant_we ? S_WR : S_RD;
                end
            end
            S_WR: begin
                if (!aw_open && !w_open) begin
                    state_d = S_BWAIT;
                end
            end
            S_BWAIT: begin
                if (m_axi_bvalid) begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (m_axi_arready) begin
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (m_axi_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // last_q resets to 1 so that port 0 wins the first contested grant.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cur_q     <= 1'b0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else if (grant_en) begin
            cur_q     <= grant_port;
            last_q    <= grant_port;
            addr_q    <= sel_addr & ~ADDR_W'(3);
            wdata_q   <= sel_wdata;
            awvalid_q <= grant_we;
            wvalid_q  <= grant_we;
        end else begin
            if (awvalid_q && m_axi_awready) begin
                awvalid_q <= 1'b0;
            end
            if (wvalid_q && m_axi_wready) begin
                wvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            done_q  <= 2'b00;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 2'b00;
            if (b_fire || r_fire) begin
                done_q <= cur_q ? 2'b10 : 2'b01;
                err_q  <= b_fire ? m_axi_bresp[1] : m_axi_rresp[1];
            end
            if (r_fire) begin
                rdata_q <= m_axi_rdata;
            end
        end
    end

    assign unused_resp_lsb = m_axi_bresp[0] ^ m_axi_rresp[0];

    assign done          = done_q;
    assign rdata         = rdata_q;
    assign err           = err_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == S_BWAIT);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = (state_q == S_RD);
    assign m_axi_rready  = (state_q == S_RWAIT);

endmodule

// File: tb/tb_memory_ctrl_cfg_arbiter.sv
// tb/tb_memory_ctrl_cfg_arbiter.sv - self-checking bench for memory_ctrl_cfg_arbiter with a behavioural AXI4-Lite slave
module tb_memory_ctrl_cfg_arbiter;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    logic        r0 = 1'b0, r1 = 1'b0, w0 = 1'b0, w1 = 1'b0;
    logic [3:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic [1:0]  req, we;
    logic [7:0]  addr;
    logic [63:0] wdata;
    assign req   = {r1, r0};
    assign we    = {w1, w0};
    assign addr  = {a1, a0};
    assign wdata = {d1, d0};

    logic [1:0]  done;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  m_axi_awaddr, m_axi_araddr;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [31:0] m_axi_wdata;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] s_rdata;

    memory_ctrl_cfg_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req(req), .we(we), .addr(addr), .wdata(wdata),
        .done(done), .rdata(rdata), .err(err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(arready),
        .m_axi_rdata(s_rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // slave configuration and state
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    bit          rand_dly = 0;
    int unsigned err_pct = 0;
    bit          force_rd = 0;
    logic [31:0] force_rdata_val = '0;
    bit          force_resp_en = 0;
    logic [1:0]  force_resp = 2'b00;

    logic [31:0] mem [4];
    logic [31:0] ref_mem [4];
    bit          aw_got, w_got, ar_got;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic [3:0]  aw_addr_s, ar_addr_s;
    logic [31:0] w_data_s;
    logic [1:0]  slv_last_resp = 2'b00;
    logic [3:0]  slv_last_waddr = '0;
    logic [31:0] slv_last_wdata = '0;
    logic        s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
    logic [3:0]  s_awaddr, s_araddr;
    logic [31:0] s_wdata;

    task drive_ready();
        awready = (aw_cnt >= aw_dly);
        wready  = (w_cnt >= w_dly);
        arready = (ar_cnt >= ar_dly);
    endtask

    task slave_clear();
        for (int i = 0; i < 4; i++) mem[i] = '0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        bvalid = 1'b0; rvalid = 1'b0; bresp = 2'b00; rresp = 2'b00; s_rdata = '0;
        drive_ready();
    endtask

    function automatic logic [1:0] pick_resp();
        if (force_resp_en) return force_resp;
        return ($urandom_range(0, 99) < err_pct) ? 2'b10 : 2'b00;
    endfunction

    // Slave: samples master outputs mid-cycle, applies the handshakes of the
    // following edge just after it, then drives its next ready/valid values.
    initial begin
        slave_clear();
        forever begin
            @(negedge ACLK);
            s_awvalid = m_axi_awvalid; s_wvalid = m_axi_wvalid; s_arvalid = m_axi_arvalid;
            s_bready = m_axi_bready; s_rready = m_axi_rready;
            s_awaddr = m_axi_awaddr; s_araddr = m_axi_araddr; s_wdata = m_axi_wdata;
            @(posedge ACLK);
            #1;
            if (!ARESETN) begin
                slave_clear();
            end else begin
                if (s_awvalid && awready) begin
                    aw_got = 1; aw_addr_s = s_awaddr; aw_cnt = 0;
                    if (rand_dly) aw_dly = $urandom_range(0, 3);
                end else if (s_awvalid) aw_cnt++;
                if (s_wvalid && wready) begin
                    w_got = 1; w_data_s = s_wdata; w_cnt = 0;
                    if (rand_dly) w_dly = $urandom_range(0, 3);
                end else if (s_wvalid) w_cnt++;
                if (s_arvalid && arready) begin
                    ar_got = 1; ar_addr_s = s_araddr; ar_cnt = 0;
                    if (rand_dly) ar_dly = $urandom_range(0, 3);
                end else if (s_arvalid) ar_cnt++;
                if (bvalid && s_bready) bvalid = 1'b0;
                if (rvalid && s_rready) rvalid = 1'b0;
                if (aw_got && w_got) begin
                    if (b_cnt >= b_dly) begin
                        mem[aw_addr_s[3:2]] = w_data_s;
                        slv_last_waddr = aw_addr_s; slv_last_wdata = w_data_s;
                        bresp = pick_resp(); slv_last_resp = bresp;
                        bvalid = 1'b1; aw_got = 0; w_got = 0; b_cnt = 0;
                        if (rand_dly) b_dly = $urandom_range(0, 3);
                    end else b_cnt++;
                end
                if (ar_got) begin
                    if (r_cnt >= r_dly) begin
                        s_rdata = force_rd ? force_rdata_val : mem[ar_addr_s[3:2]];
                        rresp = pick_resp(); slv_last_resp = rresp;
                        rvalid = 1'b1; ar_got = 0; r_cnt = 0;
                        if (rand_dly) r_dly = $urandom_range(0, 3);
                    end else r_cnt++;
                end
                drive_ready();
            end
        end
    end

    // Monitor: fairness rule -- if the other port is requesting when a port
    // completes, the other port must be the next one to complete.
    int         awv_cyc = 0, wv_cyc = 0, bhs_cyc = 0, done_cyc = 0;
    bit         exp_valid = 0;
    logic [1:0] exp_done = 2'b00;
    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                exp_valid = 0;
            end else begin
                if (m_axi_awvalid) awv_cyc++;
                if (m_axi_wvalid) wv_cyc++;
                if (bvalid && m_axi_bready) bhs_cyc++;
                if (done != 2'b00) begin
                    done_cyc++;
                    chk("done_onehot", 64'($countones(done)), 1);
                    if (exp_valid) chk("rr_order", done, exp_done);
                    exp_valid = ((req & ~done) != 2'b00);
                    exp_done  = ~done;
                end
            end
        end
    end

    task automatic do_txn(input int p, input logic wr, input logic [3:0] ad, input logic [31:0] wd,
                          output logic [31:0] rd_o, output logic err_o);
        logic        got;
        logic [31:0] exp_rd;
        rd_o = '0; err_o = 1'b0; got = 1'b0;
        @(posedge ACLK);
        #1;
        if (p == 0) begin r0 = 1'b1; w0 = wr; a0 = ad; d0 = wd; end
        else begin r1 = 1'b1; w1 = wr; a1 = ad; d1 = wd; end
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge ACLK);
            if (done[p]) got = 1'b1;
        end
        if (!got) begin
            chk($sformatf("timeout_p%0d", p), 0, 1);
        end else begin
            rd_o = rdata; err_o = err;
            chk($sformatf("done_p%0d", p), done, (p == 0) ? 2'b01 : 2'b10);
            chk("err", err, slv_last_resp[1]);
            if (wr) begin
                chk("wr_addr", slv_last_waddr, {ad[3:2], 2'b00});
                chk("wr_data", slv_last_wdata, wd);
                ref_mem[ad[3:2]] = wd;
            end else begin
                exp_rd = force_rd ? force_rdata_val : ref_mem[ad[3:2]];
                chk("rd_data", rdata, exp_rd);
            end
        end
        @(posedge ACLK);
        #1;
        if (p == 0) r0 = 1'b0; else r1 = 1'b0;
        @(negedge ACLK);
        if (got) chk("done_width", done[p], 0);
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        logic        got_b;
        int          n, dc;
        logic [1:0]  seq [4];

        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        repeat (3) @(negedge ACLK);
        chk("rst_done", done, 0);
        chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        ARESETN = 1'b1;

        // single write, zero-wait latency
        @(posedge ACLK); #1;
        r0 = 1'b1; w0 = 1'b1; a0 = 4'h0; d0 = 32'h1;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("t2_awvalid", m_axi_awvalid, 1);
        chk("t2_wvalid", m_axi_wvalid, 1);
        chk("t2_awaddr", m_axi_awaddr, 0);
        chk("t2_wdata", m_axi_wdata, 1);
        @(negedge ACLK);
        chk("t2_bready", m_axi_bready, 1);
        @(negedge ACLK);
        chk("t2_done", done, 2'b01);
        chk("t2_err", err, 0);
        ref_mem[0] = 32'h1;
        @(posedge ACLK); #1;
        r0 = 1'b0;
        @(negedge ACLK);
        chk("t2_done_width", done, 0);

        // write four registers, read back with unaligned addresses
        for (int i = 0; i < 4; i++) do_txn(0, 1'b1, 4'(i * 4), 32'(i + 1), rd, e);
        for (int i = 0; i < 4; i++) begin
            do_txn(0, 1'b0, 4'(i * 5), 32'h0, rd, e);
            chk($sformatf("t3_readback%0d", i), rd, 32'(i + 1));
        end

        // awready delayed three cycles, wready immediate
        aw_dly = 3;
        awv_cyc = 0; wv_cyc = 0; bhs_cyc = 0; done_cyc = 0;
        do_txn(0, 1'b1, 4'h8, 32'h55, rd, e);
        chk("t5_awvalid_cycles", awv_cyc, 4);
        chk("t5_wvalid_cycles", wv_cyc, 1);
        chk("t5_b_handshakes", bhs_cyc, 1);
        chk("t5_done_count", done_cyc, 1);
        aw_dly = 0;

        // read with SLVERR
        force_rd = 1; force_rdata_val = 32'hDEADBEEF; force_resp_en = 1; force_resp = 2'b10;
        do_txn(0, 1'b0, 4'h4, 32'h0, rd, e);
        chk("t6_err", e, 1);
        chk("t6_rdata", rd, 32'hDEADBEEF);
        force_rd = 0; force_resp_en = 0;

        // both ports requesting from reset
        ARESETN = 1'b0;
        r0 = 1'b1; r1 = 1'b1; w0 = 1'b1; w1 = 1'b1; a0 = 4'h0; a1 = 4'h4; d0 = 32'hA0; d1 = 32'hA1;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge ACLK);
            if (done != 2'b00) begin seq[n] = done; n++; end
        end
        chk("t4_count", n, 4);
        for (int i = 0; i < n; i++) chk($sformatf("t4_grant%0d", i), seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        @(posedge ACLK); #1;
        r0 = 1'b0; r1 = 1'b0;
        repeat (6) @(negedge ACLK);

        // reset while waiting for B
        b_dly = 6;
        @(posedge ACLK); #1;
        r0 = 1'b1; w0 = 1'b1; a0 = 4'h4; d0 = 32'h77;
        got_b = 1'b0;
        for (int c = 0; c < 50 && !got_b; c++) begin
            @(negedge ACLK);
            if (m_axi_bready) got_b = 1'b1;
        end
        chk("t7_reach_bwait", got_b, 1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("t7_abort_outputs", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, done}, 0);
        r0 = 1'b0;
        dc = done_cyc;
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        b_dly = 0;
        repeat (4) @(negedge ACLK);
        chk("t7_no_done", done_cyc, dc);
        @(posedge ACLK); #1;
        r0 = 1'b1; r1 = 1'b1; w0 = 1'b1; w1 = 1'b1;
        got_b = 1'b0;
        for (int c = 0; c < 50 && !got_b; c++) begin
            @(negedge ACLK);
            if (done != 2'b00) got_b = 1'b1;
        end
        chk("t7_first_grant", done, 2'b01);
        @(posedge ACLK); #1;
        r0 = 1'b0; r1 = 1'b0;
        repeat (8) @(negedge ACLK);

        // randomized traffic from both ports
        do_reset();
        rand_dly = 1; err_pct = 12;
        fork
            begin
                logic [31:0] x0;
                logic        y0;
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge ACLK);
                    do_txn(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, x0, y0);
                end
            end
            begin
                logic [31:0] x1;
                logic        y1;
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge ACLK);
                    do_txn(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, x1, y1);
                end
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
